// File: rtl/skin_segm_pkg.sv
// Shared constants for the skin segmentation / bounding-box stage.
package skin_segm_pkg;
   localparam logic [1:0] MODE_PASS = 2'd0;
   localparam logic [1:0] MODE_MASK = 2'd1;
   localparam logic [1:0] MODE_CUT  = 2'd2;
   localparam logic [1:0] MODE_BOX  = 2'd3;

   localparam logic [7:0] DEF_CB_MIN = 8'd77;
   localparam logic [7:0] DEF_CB_MAX = 8'd127;
   localparam logic [7:0] DEF_CR_MIN = 8'd133;
   localparam logic [7:0] DEF_CR_MAX = 8'd173;
endpackage

// File: rtl/skin_segm_bbox_frame_coord_counter.sv
// Frame boundary detection, first-frame flag and saturating x/y
// pixel coordinates for the skin segmentation stage.
module frame_coord_counter #(
   parameter int   X_W    = 11,
   parameter int   Y_W    = 11,
   parameter logic VS_ACT = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ce,
   input  logic           in_vsync,
   input  logic           in_de,
   output logic           fb,
   output logic           first,
   output logic [X_W-1:0] col,
   output logic [Y_W-1:0] row
);

   localparam logic [X_W-1:0] X_ONE = X_W'(1);
   localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

   logic           vs_q;
   logic           de_q;
   logic           first_q;
   logic [X_W-1:0] x_q;
   logic [Y_W-1:0] y_q;
   logic [Y_W-1:0] y_base;
   logic           fall;

   assign fb     = ce && (in_vsync == VS_ACT) && (vs_q != VS_ACT);
   assign fall   = de_q && !in_de;
   assign first  = first_q;
   // a pixel on the boundary cycle already sits on row 0
   assign y_base = fb ? '0 : y_q;
   assign col    = x_q;
   assign row    = y_base;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q    <= VS_ACT;
         de_q    <= 1'b0;
         first_q <= 1'b1;
         x_q     <= '0;
         y_q     <= '0;
      end else if (ce) begin
         vs_q <= in_vsync;
         de_q <= in_de;
         if (fb)
            first_q <= 1'b0;
         if (fall)
            x_q <= '0;
         else if (in_de && (x_q != '1))
            x_q <= x_q + X_ONE;
         if (fall && (y_base != '1))
            y_q <= y_base + Y_ONE;
         else
            y_q <= y_base;
      end
   end

endmodule

// File: rtl/skin_segm_bbox.sv
// Skin-colour segmentation with per-frame pixel count and bounding box,
// two-stage pixel pipeline with four display modes.
module skin_segm_bbox
   import skin_segm_pkg::*;
#(
   parameter int   DATA_W = 8,
   parameter int   X_W    = 11,
   parameter int   Y_W    = 11,
   parameter int   CNT_W  = 22,
   parameter logic VS_ACT = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce,
   input  logic [DATA_W-1:0] Y,
   input  logic [DATA_W-1:0] Cb,
   input  logic [DATA_W-1:0] Cr,
   input  logic              in_hsync,
   input  logic              in_vsync,
   input  logic              in_de,
   input  logic [DATA_W-1:0] cb_min,
   input  logic [DATA_W-1:0] cb_max,
   input  logic [DATA_W-1:0] cr_min,
   input  logic [DATA_W-1:0] cr_max,
   input  logic [1:0]        mode,
   output logic [DATA_W-1:0] out_Y,
   output logic [DATA_W-1:0] out_Cb,
   output logic [DATA_W-1:0] out_Cr,
   output logic              out_hsync,
   output logic              out_vsync,
   output logic              out_de,
   output logic              out_mask,
   output logic [X_W-1:0]    bbox_x_min,
   output logic [X_W-1:0]    bbox_x_max,
   output logic [Y_W-1:0]    bbox_y_min,
   output logic [Y_W-1:0]    bbox_y_max,
   output logic [CNT_W-1:0]  pix_count,
   output logic              bbox_valid,
   output logic              frame_done
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef struct packed {
      logic [DATA_W-1:0] luma;
      logic [DATA_W-1:0] cb;
      logic [DATA_W-1:0] cr;
      logic              hs;
      logic              vs;
      logic              de;
      logic              mask;
      logic [X_W-1:0]    col;
      logic [Y_W-1:0]    row;
   } s1_t;

   logic              fb;
   logic              first;
   logic              publish;
   logic [X_W-1:0]    col;
   logic [Y_W-1:0]    row;

   logic [DATA_W-1:0] cb_min_q, cb_max_q, cr_min_q, cr_max_q;
   logic [DATA_W-1:0] cb_lo, cb_hi, cr_lo, cr_hi;
   logic [1:0]        mode_q;
   logic              hit;
   s1_t               s1;

   logic [CNT_W-1:0]  acc_cnt, cnt_b, cnt_n;
   logic [X_W-1:0]    acc_x0, acc_x1, x0_b, x1_b, x0_n, x1_n;
   logic [Y_W-1:0]    acc_y0, acc_y1, y0_b, y1_b, y0_n, y1_n;

   logic [CNT_W-1:0]  res_cnt;
   logic [X_W-1:0]    res_x0, res_x1;
   logic [Y_W-1:0]    res_y0, res_y1;

   logic [DATA_W-1:0] ny, ncb, ncr;
   logic              in_x, in_y, on_box;

   frame_coord_counter #(
      .X_W    (X_W),
      .Y_W    (Y_W),
      .VS_ACT (VS_ACT)
   ) u_coord (
      .clk      (clk),
      .rst_n    (rst_n),
      .ce       (ce),
      .in_vsync (in_vsync),
      .in_de    (in_de),
      .fb       (fb),
      .first    (first),
      .col      (col),
      .row      (row)
   );

   assign publish = fb && !first;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cb_min_q <= '0;
         cb_max_q <= '0;
         cr_min_q <= '0;
         cr_max_q <= '0;
         mode_q   <= MODE_PASS;
      end else if (fb) begin
         cb_min_q <= cb_min;
         cb_max_q <= cb_max;
         cr_min_q <= cr_min;
         cr_max_q <= cr_max;
         mode_q   <= mode;
      end
   end

   // the boundary pixel is judged with the new frame's window
   assign cb_lo = fb ? cb_min : cb_min_q;
   assign cb_hi = fb ? cb_max : cb_max_q;
   assign cr_lo = fb ? cr_min : cr_min_q;
   assign cr_hi = fb ? cr_max : cr_max_q;
   assign hit   = in_de && (Cb >= cb_lo) && (Cb <= cb_hi)
               && (Cr >= cr_lo) && (Cr <= cr_hi);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         s1 <= '0;
      else if (ce)
         s1 <= '{luma: Y, cb: Cb, cr: Cr,
                 hs: in_hsync, vs: in_vsync, de: in_de,
                 mask: hit, col: col, row: row};
   end

   always_comb begin
      cnt_b = fb ? '0 : acc_cnt;
      x0_b  = fb ? '0 : acc_x0;
      x1_b  = fb ? '0 : acc_x1;
      y0_b  = fb ? '0 : acc_y0;
      y1_b  = fb ? '0 : acc_y1;
      cnt_n = cnt_b;
      x0_n  = x0_b;
      x1_n  = x1_b;
      y0_n  = y0_b;
      y1_n  = y1_b;
      if (hit) begin
         if (cnt_b != '1)
            cnt_n = cnt_b + CNT_ONE;
         if (cnt_b == '0) begin
            x0_n = col;
            x1_n = col;
            y0_n = row;
            y1_n = row;
         end else begin
            if (col < x0_b) x0_n = col;
            if (col > x1_b) x1_n = col;
            if (row < y0_b) y0_n = row;
            if (row > y1_b) y1_n = row;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_cnt <= '0;
         acc_x0  <= '0;
         acc_x1  <= '0;
         acc_y0  <= '0;
         acc_y1  <= '0;
      end else if (ce) begin
         acc_cnt <= cnt_n;
         acc_x0  <= x0_n;
         acc_x1  <= x1_n;
         acc_y0  <= y0_n;
         acc_y1  <= y1_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_cnt    <= '0;
         res_x0     <= '0;
         res_x1     <= '0;
         res_y0     <= '0;
         res_y1     <= '0;
         frame_done <= 1'b0;
      end else if (ce) begin
         frame_done <= publish;
         if (publish) begin
            res_cnt <= acc_cnt;
            res_x0  <= acc_x0;
            res_x1  <= acc_x1;
            res_y0  <= acc_y0;
            res_y1  <= acc_y1;
         end
      end
   end

   assign pix_count  = res_cnt;
   assign bbox_valid = |res_cnt;
   assign bbox_x_min = res_x0;
   assign bbox_x_max = res_x1;
   assign bbox_y_min = res_y0;
   assign bbox_y_max = res_y1;

   always_comb begin
      in_x   = (s1.col >= res_x0) && (s1.col <= res_x1);
      in_y   = (s1.row >= res_y0) && (s1.row <= res_y1);
      on_box = bbox_valid
            && ((((s1.col == res_x0) || (s1.col == res_x1)) && in_y)
             || (((s1.row == res_y0) || (s1.row == res_y1)) && in_x));
      ny  = s1.luma;
      ncb = s1.cb;
      ncr = s1.cr;
      unique case (1'b1)
         (mode_q == MODE_PASS): ;
         (mode_q == MODE_MASK): begin
            ny  = s1.mask ? '1 : '0;
            ncb = s1.mask ? '1 : '0;
            ncr = s1.mask ? '1 : '0;
         end
         (mode_q == MODE_CUT): begin
            if (!s1.mask) begin
               ny  = '0;
               ncb = '0;
               ncr = '0;
            end
         end
         (mode_q == MODE_BOX): begin
            if (on_box) begin
               ny  = '1;
               ncb = '1;
               ncr = '1;
            end
         end
         default: ;
      endcase
      if (!s1.de) begin
         ny  = '0;
         ncb = '0;
         ncr = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_Y     <= '0;
         out_Cb    <= '0;
         out_Cr    <= '0;
         out_hsync <= 1'b0;
         out_vsync <= 1'b0;
         out_de    <= 1'b0;
         out_mask  <= 1'b0;
      end else if (ce) begin
         out_Y     <= ny;
         out_Cb    <= ncb;
         out_Cr    <= ncr;
         out_hsync <= s1.hs;
         out_vsync <= s1.vs;
         out_de    <= s1.de;
         out_mask  <= s1.mask;
      end
   end

endmodule
